div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div: multi-cycle 32-bit integer divider (DIV / DIVU) for the execute stage.
// Restoring division: one quotient bit per clock on a 65-bit
// {partial remainder, dividend} register, then a sign fixup.
//
// Handshake: the execute stage raises start_i with the operands and
// signed_div_i, and holds start_i high until it sees ready_o. The operands
// are captured on the edge that accepts start_i in IDLE. ready_o marks
// result_o valid and stays high (result stable) for as long as start_i is
// held. Dropping start_i in DONE returns to IDLE. annul_i aborts a division
// in ZERO or BUSY; in DONE it is ignored.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request
//   annul_i       abort in-flight division (pipeline flush)
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
//   dbg_state_o   current FSM state (IDLE=0, ZERO=1, BUSY=2, DONE=3)
// -----------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q,  state_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [64:0] dreg_q,   dreg_d;
  logic [31:0] dvsr_q,   dvsr_d;
  logic        neg_q_q,  neg_q_d;
  logic        neg_r_q,  neg_r_d;
  logic [63:0] result_q, result_d;
  logic        ready_q,  ready_d;

  logic [31:0] mag1, mag2;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [31:0] quot_fix, rem_fix;

  // Operand magnitudes: two's complement only for negative signed operands.
  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // The partial remainder never exceeds the divisor, so after the shift the
  // top 33 bits always hold it without overflow.
  assign shifted = dreg_q << 1;
  assign trial   = shifted[64:32] - {1'b0, dvsr_q};

  assign quot_fix = neg_q_q ? (~dreg_q[31:0]  + 32'd1) : dreg_q[31:0];
  assign rem_fix  = neg_r_q ? (~dreg_q[63:32] + 32'd1) : dreg_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dreg_d   = dreg_q;
    dvsr_d   = dvsr_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = ZERO;
          end else begin
            state_d = BUSY;
            cnt_d   = 6'd0;
            dreg_d  = {33'h0, mag1};
            dvsr_d  = mag2;
            neg_q_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r_d = signed_div_i && opdata1_i[31];
          end
        end
      end

      ZERO: begin
        result_d = 64'h0;
        if (annul_i) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end

      BUSY: begin
        // annul_i is checked first so it wins over completion.
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end else if (cnt_q == 6'd32) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {rem_fix, quot_fix};
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!trial[32]) begin
            dreg_d = {trial, shifted[31:1], 1'b1};
          end else begin
            dreg_d = shifted;
          end
        end
      end

      DONE: begin
        if (!start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = 64'h0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      dreg_q   <= 65'h0;
      dvsr_q   <= 32'h0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= 64'h0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dreg_q   <= dreg_d;
      dvsr_q   <= dvsr_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule
